// File: rtl/byte_word_assembler.sv
// Gathers four bytes from the byte-source mux into one 32-bit word (IDLE/FETCH/HOLD).
// Define BYTE_WORD_ASSEMBLER_BIG_ENDIAN_EN to place byte 0 in word_out[31:24].
module byte_word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_src,
  output logic        mux_sel,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic [1:0]  byte_idx,
  output logic [31:0] word_out,
  output logic        word_valid,
  input  logic        word_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_q;
  logic        mux_sel_q;
  logic [1:0]  byte_idx_q;
  logic [31:0] word_q;
  logic [1:0]  lane_d;
  logic [31:0] word_d;

`ifdef BYTE_WORD_ASSEMBLER_BIG_ENDIAN_EN
  assign lane_d = 2'd3 - byte_idx_q;
`else
  assign lane_d = byte_idx_q;
`endif

  // Only the lane selected by the current byte index takes the incoming byte.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign word_d[8*gi +: 8] = (lane_d == 2'(gi)) ? byte_in : word_q[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mux_sel_q  <= 1'b0;
      byte_idx_q <= 2'd0;
      word_q     <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            mux_sel_q  <= req_src;
            byte_idx_q <= 2'd0;
            state_q    <= FETCH;
          end
        end
        FETCH: begin
          if (byte_valid) begin
            word_q     <= word_d;
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) state_q <= HOLD;
          end
        end
        HOLD: begin
          if (word_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake outputs decode the state register only, never an input.
  assign req_ready  = (state_q == IDLE);
  assign word_valid = (state_q == HOLD);
  assign mux_sel    = mux_sel_q;
  assign byte_idx   = byte_idx_q;
  assign word_out   = word_q;

endmodule

// File: tb/tb_byte_word_assembler.sv
// Directed self-checking bench for byte_word_assembler; follows the
// BYTE_WORD_ASSEMBLER_BIG_ENDIAN_EN define for expected word layout.
module tb_byte_word_assembler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_src = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        word_ready = 1'b0;
  logic        req_ready;
  logic        mux_sel;
  logic [1:0]  byte_idx;
  logic [31:0] word_out;
  logic        word_valid;

  int checks = 0;
  int failures = 0;

`ifdef BYTE_WORD_ASSEMBLER_BIG_ENDIAN_EN
  localparam bit BIG = 1'b1;
`else
  localparam bit BIG = 1'b0;
`endif

  byte_word_assembler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_src    (req_src),
    .mux_sel    (mux_sel),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_idx   (byte_idx),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pick(input logic [31:0] le, input logic [31:0] be);
    return BIG ? be : le;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".req_ready"},  32'(req_ready),  32'd1);
    chk({tag, ".word_valid"}, 32'(word_valid), 32'd0);
    chk({tag, ".word_out"},   word_out,        32'h0000_0000);
    chk({tag, ".mux_sel"},    32'(mux_sel),    32'd0);
    chk({tag, ".byte_idx"},   32'(byte_idx),   32'd0);
  endtask

  // Full transaction with byte_valid held high and word_ready given on the first HOLD cycle.
  task automatic run_word(input string tag, input logic src,
                          input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3,
                          input logic [31:0] exp_le, input logic [31:0] exp_be);
    logic [7:0] bytes [4];
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
    chk({tag, ".req_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_src   = src;
    tick();
    req_valid = 1'b0;
    req_src   = ~src;
    chk({tag, ".mux_sel_c1"}, 32'(mux_sel), 32'(src));
    chk({tag, ".req_ready_c1"}, 32'(req_ready), 32'd0);
    chk({tag, ".idx_c1"}, 32'(byte_idx), 32'd0);
    for (int i = 0; i < 4; i++) begin
      byte_valid = 1'b1;
      byte_in    = bytes[i];
      tick();
      chk($sformatf("%s.idx%0d", tag, i), 32'(byte_idx), 32'((i + 1) % 4));
      chk($sformatf("%s.mux_sel%0d", tag, i), 32'(mux_sel), 32'(src));
      chk($sformatf("%s.word_valid%0d", tag, i), 32'(word_valid), 32'(i == 3));
    end
    byte_valid = 1'b0;
    chk({tag, ".word_out"}, word_out, pick(exp_le, exp_be));
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    chk({tag, ".word_valid_drop"}, 32'(word_valid), 32'd0);
    chk({tag, ".req_ready_back"}, 32'(req_ready), 32'd1);
    chk({tag, ".word_out_kept"}, word_out, pick(exp_le, exp_be));
  endtask

  initial begin
    logic [7:0]  pat_bytes [4];
    logic        pat_valid [7];
    int          n;
    logic [31:0] held;

    // Reset state
    repeat (2) tick();
    chk_reset_outputs("rst_hold");
    rst_n = 1'b1;
    tick();
    chk_reset_outputs("rst_release");

    // Basic word from data memory
    run_word("t1", 1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 32'h4433_2211, 32'h1122_3344);

    // Gapped byte_valid; garbage on invalid cycles must not be captured
    pat_bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    pat_valid = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    req_valid = 1'b1;
    req_src   = 1'b0;
    tick();
    req_valid = 1'b0;
    chk("t2.mux_sel", 32'(mux_sel), 32'd0);
    n = 0;
    for (int k = 0; k < 7; k++) begin
      byte_valid = pat_valid[k];
      byte_in    = pat_valid[k] ? pat_bytes[n] : 8'hEE;
      tick();
      if (pat_valid[k]) n++;
      chk($sformatf("t2.idx_k%0d", k), 32'(byte_idx), 32'(n % 4));
      chk($sformatf("t2.word_valid_k%0d", k), 32'(word_valid), 32'(n == 4));
    end
    byte_valid = 1'b0;
    chk("t2.word_out", word_out, pick(32'hDDCC_BBAA, 32'hAABB_CCDD));

    // Long HOLD with stray requests, bytes and source toggles
    held = pick(32'hDDCC_BBAA, 32'hAABB_CCDD);
    for (int c = 0; c < 10; c++) begin
      req_valid  = 1'b1;
      req_src    = 1'b1;
      byte_valid = c[0];
      byte_in    = 8'h5A;
      word_ready = 1'b0;
      tick();
      chk($sformatf("t3.word_valid_c%0d", c), 32'(word_valid), 32'd1);
      chk($sformatf("t3.word_out_c%0d", c), word_out, held);
      chk($sformatf("t3.req_ready_c%0d", c), 32'(req_ready), 32'd0);
      chk($sformatf("t3.mux_sel_c%0d", c), 32'(mux_sel), 32'd0);
      chk($sformatf("t3.idx_c%0d", c), 32'(byte_idx), 32'd0);
    end
    // Handshake cycle: the pending request must not be taken yet
    byte_valid = 1'b0;
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    chk("t3.req_ready_after", 32'(req_ready), 32'd1);
    chk("t3.word_valid_after", 32'(word_valid), 32'd0);
    chk("t3.mux_sel_after", 32'(mux_sel), 32'd0);
    // Request still asserted is accepted now
    tick();
    req_valid = 1'b0;
    chk("t4.mux_sel_accept", 32'(mux_sel), 32'd1);
    chk("t4.req_ready_accept", 32'(req_ready), 32'd0);

    // Reset in the middle of FETCH after two bytes
    byte_valid = 1'b1;
    byte_in    = 8'hF1;
    tick();
    byte_in    = 8'hF2;
    tick();
    byte_valid = 1'b0;
    chk("t4.idx_before_rst", 32'(byte_idx), 32'd2);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("t4.async_rst");
    tick();
    rst_n = 1'b1;
    tick();
    chk_reset_outputs("t4.post_rst");
    run_word("t4.new", 1'b0, 8'h01, 8'h02, 8'h03, 8'h04, 32'h0403_0201, 32'h0102_0304);

    // Back-to-back requests with toggled source
    run_word("t5.a", 1'b1, 8'h5C, 8'h3E, 8'h90, 8'h07, 32'h0790_3E5C, 32'h5C3E_9007);
    run_word("t5.b", 1'b0, 8'hC3, 8'h18, 8'hE7, 8'h81, 32'h81E7_18C3, 32'hC318_E781);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
